noc_local_ni: RTL
=================

Name: noc_local_ni

Overview:
- Local network interface between a processing element and a router's local (L) port.
- TX path: packs core requests into 16-bit flits and injects them into the router's L input, under credit-based flow control.
- RX path: buffers flits ejected from the router's L output, presents them to the core, and returns one credit per flit consumed.

Parameters:
- XCOORD, 0, X coordinate of the attached router; 4 bits used.
- YCOORD, 0, Y coordinate of the attached router; 4 bits used.
- TX_CREDITS, 4, initial credits; equals the depth of the router's L input buffer.
- RX_DEPTH, 4, RX FIFO entries; power of 2, minimum 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- tx_valid  in  1  core has a flit to send.
- tx_ready  out  1  NI accepts the flit this cycle.
- tx_dest_x  in  4  destination X.
- tx_dest_y  in  4  destination Y.
- tx_payload  in  8  payload byte.
- net_tx_data  out  16  flit to router L input.
- net_tx_enable  out  1  net_tx_data is valid (one-cycle write strobe).
- net_tx_credit  in  1  router popped one flit from its L input; +1 credit.
- net_rx_data  in  16  flit from router L output.
- net_rx_enable  in  1  net_rx_data is valid this cycle.
- net_rx_credit  out  1  one-cycle pulse: one RX entry freed.
- rx_valid  out  1  RX head is valid.
- rx_ready  in  1  core consumes the RX head.
- rx_payload  out  8  head flit bits [15:8].
- rx_dest  out  8  head flit bits [7:0].
- credit_count  out  $clog2(TX_CREDITS+1)  current TX credits.
- err_credit  out  1  sticky: credit overflow.
- err_rx_ovf  out  1  sticky: RX write while full.

Behaviour:
- Single clock domain. Reset is synchronous and active-high; all state updates on posedge clk.
- Flit format: [15:8] payload, [7:4] dest X, [3:0] dest Y. The router routes on bits [7:0].

Reset values:
- credit_count = TX_CREDITS.
- net_tx_enable = 0; net_tx_data = 0; net_rx_credit = 0.
- RX FIFO empty: rx_valid = 0; rx_payload and rx_dest = 0.
- err_credit = 0; err_rx_ovf = 0.
- Reset mid-operation discards all buffered and in-flight flits and restores full credit; the router must be reset in the same cycle.

TX path:
- tx_ready = (credit_count != 0); combinational from the registered count only.
- Accept = tx_valid & tx_ready.
- The cycle after accept: net_tx_enable = 1 and net_tx_data = {tx_payload, tx_dest_x, tx_dest_y}. Latency is exactly 1 cycle.
- Back-to-back accepts give one flit per cycle while credits remain.
- Credit update:
  - accept only: count -1.
  - net_tx_credit only: count +1.
  - both in the same cycle: count unchanged.
- Credit overflow: an increment when count == TX_CREDITS (with no accept) leaves count saturated and sets err_credit.
- count never underflows, because accept requires count > 0.
- No filtering of self-addressed flits (dest == XCOORD,YCOORD); the router returns them on L.

RX path:
- Show-ahead FIFO with RX_DEPTH entries. rx_valid = !empty; rx_payload and rx_dest come from the head entry.
- Write: net_rx_enable writes the flit at the tail.
- Pop: rx_valid & rx_ready pops the head. The next entry appears on the following cycle.
- Credit return: net_rx_credit pulses exactly one cycle after each pop, one pulse per pop, so pops in consecutive cycles give consecutive pulses.
- Simultaneous write and pop:
  - When not empty: occupancy unchanged.
  - When empty: the write lands and the pop is ignored, since rx_valid was 0.
  - When full: both are accepted and occupancy stays full.
- Write when full without a pop: the flit is dropped and err_rx_ovf is set. This cannot occur while the router holds RX_DEPTH credits.
- Pointers wrap modulo RX_DEPTH. Occupancy is held in a $clog2(RX_DEPTH)+1 bit counter.
- Error flags clear only on rst.

Test Plan:
- Reset, then tx_valid with x=2, y=3, payload=0xA5 -> next cycle net_tx_enable=1, net_tx_data=0xA523, credit_count 4->3.
- Hold tx_valid 6 cycles with no net_tx_credit -> exactly 4 flits sent; tx_ready=0 from cycle 4; credit_count=0. Pulse net_tx_credit once -> one more flit sent the next cycle.
- Assert accept and net_tx_credit in the same cycle at count=2 -> count stays 2. Pulse net_tx_credit at count=4 -> count stays 4 and err_credit=1.
- Write 0x1122, 0x3344, 0x5566 with rx_ready=0 -> rx_valid=1, rx_payload=0x11, rx_dest=0x22. Then rx_ready=1 for 3 cycles -> heads 0x11, 0x33, 0x55 in order, three consecutive net_rx_credit pulses each lagging its pop by 1 cycle, rx_valid=0 afterwards.
- Fill RX with 4 flits, then write a 5th with rx_ready=0 -> dropped, err_rx_ovf=1, head unchanged. Repeat the fill with write+pop in the same cycle -> no drop, occupancy stays 4.
- Assert rst mid-stream with 3 RX entries held and credit_count=1 -> next cycle rx_valid=0, credit_count=4, net_tx_enable=0, error flags=0.

Source files
------------

// File: rtl/noc_local_ni.sv
// rtl/noc_local_ni.sv - local network interface between a core and a router L port
// TX packs core requests into credit-controlled flits; RX buffers ejected flits and returns credits.
module noc_local_ni #(
  parameter int XCOORD     = 0,
  parameter int YCOORD     = 0,
  parameter int TX_CREDITS = 4,
  parameter int RX_DEPTH   = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              tx_valid,
  output logic                              tx_ready,
  input  logic [3:0]                        tx_dest_x,
  input  logic [3:0]                        tx_dest_y,
  input  logic [7:0]                        tx_payload,
  output logic [15:0]                       net_tx_data,
  output logic                              net_tx_enable,
  input  logic                              net_tx_credit,
  input  logic [15:0]                       net_rx_data,
  input  logic                              net_rx_enable,
  output logic                              net_rx_credit,
  output logic                              rx_valid,
  input  logic                              rx_ready,
  output logic [7:0]                        rx_payload,
  output logic [7:0]                        rx_dest,
  output logic [$clog2(TX_CREDITS+1)-1:0]   credit_count,
  output logic                              err_credit,
  output logic                              err_rx_ovf
);

  localparam int CW = $clog2(TX_CREDITS + 1);
  localparam int AW = $clog2(RX_DEPTH);
  localparam logic [CW-1:0] CREDIT_MAX = CW'(TX_CREDITS);
  localparam logic [AW:0]   RX_FULL    = (AW + 1)'(RX_DEPTH);

  // Coordinates only label the attached router; reject values that cannot fit a flit nibble.
  if (XCOORD < 0 || XCOORD > 15 || YCOORD < 0 || YCOORD > 15) begin : g_bad_coord
    $error("noc_local_ni: XCOORD/YCOORD must fit in 4 bits");
  end
  if (RX_DEPTH < 2 || (RX_DEPTH & (RX_DEPTH - 1)) != 0 || TX_CREDITS < 1) begin : g_bad_depth
    $error("noc_local_ni: RX_DEPTH must be a power of 2 >= 2 and TX_CREDITS >= 1");
  end

  logic [CW-1:0] credit_q, credit_d;
  logic          err_credit_q, err_credit_d;
  logic          net_tx_enable_q;
  logic [15:0]   net_tx_data_q;
  logic          tx_accept;

  assign tx_ready  = (credit_q != '0);
  assign tx_accept = tx_valid & tx_ready;

  always_comb begin
    credit_d     = credit_q;
    err_credit_d = err_credit_q;
    case ({tx_accept, net_tx_credit})
      2'b10:   credit_d = credit_q - CW'(1);
      2'b01: begin
        if (credit_q == CREDIT_MAX) err_credit_d = 1'b1;
        else                        credit_d     = credit_q + CW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credit_q        <= CREDIT_MAX;
      err_credit_q    <= 1'b0;
      net_tx_enable_q <= 1'b0;
      net_tx_data_q   <= '0;
    end else begin
      credit_q        <= credit_d;
      err_credit_q    <= err_credit_d;
      net_tx_enable_q <= tx_accept;
      if (tx_accept) net_tx_data_q <= {tx_payload, tx_dest_x, tx_dest_y};
    end
  end

  logic [15:0]   mem_q [RX_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q, count_d;
  logic          rx_full, rx_pop, rx_wr;
  logic          net_rx_credit_q, err_rx_ovf_q;
  logic [15:0]   rx_head;

  assign rx_valid = (count_q != '0);
  assign rx_full  = (count_q == RX_FULL);
  assign rx_pop   = rx_valid & rx_ready;
  // A pop in the same cycle frees the slot a full-FIFO write needs.
  assign rx_wr    = net_rx_enable & (~rx_full | rx_pop);
  assign rx_head  = rx_valid ? mem_q[rptr_q] : '0;

  always_comb begin
    count_d = count_q;
    case ({rx_wr, rx_pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q          <= '0;
      rptr_q          <= '0;
      count_q         <= '0;
      net_rx_credit_q <= 1'b0;
      err_rx_ovf_q    <= 1'b0;
    end else begin
      count_q         <= count_d;
      net_rx_credit_q <= rx_pop;
      if (rx_wr)  wptr_q <= wptr_q + AW'(1);
      if (rx_pop) rptr_q <= rptr_q + AW'(1);
      if (net_rx_enable && !rx_wr) err_rx_ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_wr) mem_q[wptr_q] <= net_rx_data;
  end

  assign net_tx_enable = net_tx_enable_q;
  assign net_tx_data   = net_tx_data_q;
  assign net_rx_credit = net_rx_credit_q;
  assign rx_payload    = rx_head[15:8];
  assign rx_dest       = rx_head[7:0];
  assign credit_count  = credit_q;
  assign err_credit    = err_credit_q;
  assign err_rx_ovf    = err_rx_ovf_q;

endmodule
